// File: rtl/pim_arb_pkg.sv
// pim_arb_pkg: state encoding and index sizing shared by the PIM exec arbiter and its picker.
package pim_arb_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } arb_state_e;
  function automatic int req_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pim_rr_picker.sv
// pim_rr_picker: finds the first set request at or after a start pointer, wrapping modulo N.
module pim_rr_picker import pim_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = req_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_j;
  // Scan from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_start) + k) % N);
      if (i_en && i_req[w_j]) begin
        o_found = 1'b1;
        o_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/pim_exec_arbiter.sv
// pim_exec_arbiter: round-robin sharing of one PIM exec unit with per-command grant locking and a
// watchdog that reclaims abandoned locks. The opcode rides at exec_cmd[CMD_WIDTH-1 -: 8] untouched.
module pim_exec_arbiter import pim_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int CMD_WIDTH = 64,
  parameter int LOCK_TIMEOUT = 256,
  localparam int IW = req_idx_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_done,
  output logic                         exec_start,
  output logic [CMD_WIDTH-1:0]         exec_cmd,
  input  logic                         exec_ready,
  input  logic                         exec_done,
  output logic [IW-1:0]                grant_idx,
  output logic                         busy,
  output logic                         lock_timeout,
  output logic                         err_spurious_done
);
  localparam int WW = req_idx_w(LOCK_TIMEOUT);

  if (NUM_REQ < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $fatal(1, "pim_exec_arbiter: NUM_REQ and LOCK_TIMEOUT must be >= 1");
  end

  arb_state_e r_state, w_next;
  logic [IW-1:0] r_rr_ptr, r_grant, w_idx, w_grant_inc;
  logic [CMD_WIDTH-1:0] r_cmd;
  logic [CMD_WIDTH-1:0] w_cmd [NUM_REQ];
  logic [NUM_REQ-1:0] r_done, w_grant_oh, w_pick_req;
  logic [WW-1:0] r_wd;
  logic r_lock_q, r_timeout, r_err, w_found, w_pick_en, w_wd_exp, w_done_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign w_cmd[g] = req_cmd[g*CMD_WIDTH +: CMD_WIDTH];
  end

  assign w_grant_oh = NUM_REQ'(1) << r_grant;
  assign w_grant_inc = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
  assign w_pick_en = (r_state == S_IDLE) || (r_state == S_LOCKED);
  // While locked only the holder's valid reaches the picker, so the start pointer is irrelevant.
  assign w_pick_req = (r_state == S_LOCKED) ? (req_valid & w_grant_oh) : req_valid;
  assign w_done_ok = (r_state == S_WAIT) && exec_done;
  assign w_wd_exp = (r_state == S_LOCKED) && !w_found && (r_wd == WW'(LOCK_TIMEOUT - 1));

  pim_rr_picker #(.N(NUM_REQ)) u_pick (
    .i_req   (w_pick_req),
    .i_en    (w_pick_en),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LOCKED: w_next = w_found ? S_ISSUE : (w_wd_exp ? S_IDLE : r_state);
      S_ISSUE:          w_next = exec_ready ? S_WAIT : S_ISSUE;
      S_WAIT:           w_next = exec_done ? (r_lock_q ? S_LOCKED : S_IDLE) : S_WAIT;
      default:          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant <= '0;
      r_cmd <= '0;
      r_lock_q <= 1'b0;
      r_wd <= '0;
      r_done <= '0;
      r_timeout <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= w_done_ok ? w_grant_oh : '0;
      r_timeout <= w_wd_exp;
      r_err <= r_err | (exec_done && r_state != S_WAIT);
      r_wd <= (r_state == S_LOCKED && !w_found && !w_wd_exp) ? r_wd + WW'(1) : '0;
      if (w_found) begin
        r_cmd <= w_cmd[w_idx];
        r_lock_q <= req_lock[w_idx];
        r_grant <= w_idx;
      end
      if ((w_done_ok && !r_lock_q) || w_wd_exp) r_rr_ptr <= w_grant_inc;
    end
  end

  assign req_ready = w_found ? (NUM_REQ'(1) << w_idx) : '0;
  assign req_done = r_done;
  assign exec_start = (r_state == S_ISSUE);
  assign exec_cmd = r_cmd;
  assign grant_idx = r_grant;
  assign busy = (r_state != S_IDLE);
  assign lock_timeout = r_timeout;
  assign err_spurious_done = r_err;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (exec_start && !exec_ready) |=> $stable(exec_cmd));
endmodule
